// File: rtl/simon_pkg.sv
// Shared definitions for the Simon key schedule: z sequences, round/z lookups
// and the controller state type.
package simon_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} ks_state_e;

  // Leftmost digit of each constant is sequence bit 0.
  localparam logic [61:0] Z_SEQ [5] = '{
    62'b11111010001001010110000111001101111101000100101011000011100110,
    62'b10001110111110010011000010110101000111011111001001100001011010,
    62'b10101111011100000011010010011000101000010001111110010110110011,
    62'b11011011101011000110010111100000010010001010011100110100001111,
    62'b11010001111001101011011000100000010111000011001010010011101111
  };

  // Returns 0 for any (n, m) pair that is not a standard Simon configuration.
  function automatic int simon_rounds(input int n, input int m);
    case (n)
      16:      return (m == 4) ? 32 : 0;
      24:      return (m == 3 || m == 4) ? 36 : 0;
      32:      return (m == 3) ? 42 : (m == 4) ? 44 : 0;
      48:      return (m == 2) ? 52 : (m == 3) ? 54 : 0;
      64:      return (m == 2) ? 68 : (m == 3) ? 69 : (m == 4) ? 72 : 0;
      default: return 0;
    endcase
  endfunction

  function automatic int simon_zi(input int n, input int m);
    case (n)
      16:      return 0;
      24:      return (m == 3) ? 0 : 1;
      32:      return (m == 3) ? 2 : 3;
      48:      return (m == 2) ? 2 : 3;
      64:      return (m == 2) ? 2 : (m == 3) ? 3 : 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit simon_cfg_legal(input int n, input int m);
    return simon_rounds(n, m) != 0;
  endfunction

endpackage

// File: rtl/simon_ks_round.sv
// Combinational Simon key expansion step: produces the next window word
// from the current window and the z-sequence bit.
module simon_ks_round #(
  parameter int N = 32,
  parameter int M = 4
) (
  input  logic [N*M-1:0] w,
  input  logic           z_bit,
  output logic [N-1:0]   f
);

  function automatic logic [N-1:0] ror(input logic [N-1:0] x, input int unsigned r);
    return (x >> r) | (x << (N - r));
  endfunction

  logic [N-1:0] t;
  logic [N-1:0] u;

  always_comb begin
    t = ror(w[N*(M-1) +: N], 3);
    if (M == 4) t = t ^ w[N +: N];
    u = t ^ ror(t, 1);
    f = ~w[0 +: N] ^ u ^ {{(N-2){1'b0}}, 2'b11} ^ {{(N-1){1'b0}}, z_bit};
  end

endmodule

// File: rtl/simon_key_schedule.sv
// Sequential Simon key schedule: loads an M-word master key and streams
// round keys k_0..k_{T-1} over valid/ready, one per cycle.
module simon_key_schedule
  import simon_pkg::*;
#(
  parameter  int N  = 32,
  parameter  int M  = 4,
  localparam int T  = simon_rounds(N, M),
  localparam int ZI = simon_zi(N, M),
  localparam int IW = $clog2((T > 1) ? T : 2)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N*M-1:0] key_in,
  input  logic           start,
  input  logic           abort,
  output logic           busy,
  output logic           rk_valid,
  input  logic           rk_ready,
  output logic [N-1:0]   rk_data,
  output logic [IW-1:0]  rk_idx,
  output logic           done
);

  if (!simon_cfg_legal(N, M)) begin : g_bad_cfg
    $error("simon_key_schedule: unsupported (N, M) configuration");
  end

  localparam logic [61:0] ZSEQ = Z_SEQ[ZI];

  ks_state_e     state_q, state_d;
  logic [N-1:0]  w_q [M];
  logic [N-1:0]  w_d [M];
  logic [IW-1:0] cnt_q, cnt_d;
  logic [5:0]    zp_q, zp_d;
  logic [N*M-1:0] w_flat;
  logic [N-1:0]  f_next;
  logic          z_bit;

  always_comb begin
    w_flat = '0;
    for (int unsigned j = 0; j < M; j++) w_flat[N*j +: N] = w_q[j];
  end

  assign z_bit = ZSEQ[6'd61 - zp_q];

  simon_ks_round #(.N(N), .M(M)) u_round (
    .w     (w_flat),
    .z_bit (z_bit),
    .f     (f_next)
  );

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    cnt_d   = cnt_q;
    zp_d    = zp_q;
    case (state_q)
      IDLE: begin
        if (!abort && start) begin
          for (int unsigned j = 0; j < M; j++) w_d[j] = key_in[N*j +: N];
          cnt_d   = '0;
          zp_d    = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (rk_ready) begin
          // Slide the window; the new tail word is k_{cnt+M}.
          for (int unsigned j = 0; j + 1 < M; j++) w_d[j] = w_q[j+1];
          w_d[M-1] = f_next;
          cnt_d    = cnt_q + 1'b1;
          zp_d     = (zp_q == 6'd61) ? '0 : zp_q + 1'b1;
          if (cnt_q == IW'(T - 1)) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      w_q     <= '{default: '0};
      cnt_q   <= '0;
      zp_q    <= '0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      cnt_q   <= cnt_d;
      zp_q    <= zp_d;
    end
  end

  assign busy     = (state_q == RUN);
  assign rk_valid = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign rk_data  = w_q[0];
  assign rk_idx   = cnt_q;

endmodule

// File: tb/tb_simon_key_schedule.sv
// Self-checking bench for simon_key_schedule: directed vectors, backpressure,
// abort/restart, async reset and a random-key sweep over all ten configurations.
module tb_simon_key_schedule;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  int unsigned nvec = 0;
  int unsigned nerr = 0;
  int unsigned sweep_fin = 0;
  bit          sweep_go = 1'b0;

  string ZS [5] = '{
    "11111010001001010110000111001101111101000100101011000011100110",
    "10001110111110010011000010110101000111011111001001100001011010",
    "10101111011100000011010010011000101000010001111110010110110011",
    "11011011101011000110010111100000010010001010011100110100001111",
    "11010001111001101011011000100000010111000011001010010011101111"
  };

  localparam int CFG_N [10] = '{16, 24, 24, 32, 32, 48, 48, 64, 64, 64};
  localparam int CFG_M [10] = '{ 4,  3,  4,  3,  4,  2,  3,  2,  3,  4};
  localparam int CFG_T [10] = '{32, 36, 36, 42, 44, 52, 54, 68, 69, 72};
  localparam int CFG_Z [10] = '{ 0,  0,  1,  2,  3,  2,  3,  2,  3,  4};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic mark_sweep_done();
    sweep_fin++;
  endtask

  function automatic longint unsigned rorn(input longint unsigned x, input int r, input int n);
    longint unsigned mask = (n == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << n) - 64'd1);
    x = x & mask;
    return ((x >> r) | (x << (n - r))) & mask;
  endfunction

  // Textbook Simon key expansion over the whole key list.
  function automatic void model_keys(input int n, input int m, input int zi, input int t,
                                     input logic [255:0] key, output longint unsigned ks [72]);
    longint unsigned mask = (n == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << n) - 64'd1);
    logic [255:0] sh;
    longint unsigned tmp;
    longint unsigned zb;
    for (int i = 0; i < 72; i++) ks[i] = 0;
    for (int i = 0; i < m; i++) begin
      sh = key >> (n * i);
      ks[i] = sh[63:0] & mask;
    end
    for (int i = m; i < t; i++) begin
      tmp = rorn(ks[i-1], 3, n);
      if (m == 4) tmp = tmp ^ ks[i-3];
      tmp = tmp ^ rorn(tmp, 1, n);
      zb = (ZS[zi][(i - m) % 62] == "1") ? 64'd1 : 64'd0;
      ks[i] = (~ks[i-m] ^ tmp ^ 64'd3 ^ zb) & mask;
    end
  endfunction

  // Main instance: N=32, M=4
  logic [127:0] m_key;
  logic         m_start, m_abort, m_busy, m_valid, m_ready, m_done;
  logic [31:0]  m_data;
  logic [5:0]   m_idx;

  simon_key_schedule #(.N(32), .M(4)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_in   (m_key),
    .start    (m_start),
    .abort    (m_abort),
    .busy     (m_busy),
    .rk_valid (m_valid),
    .rk_ready (m_ready),
    .rk_data  (m_data),
    .rk_idx   (m_idx),
    .done     (m_done)
  );

  task automatic run_main(input logic [127:0] key, input bit stall,
                          output longint unsigned cap [72], output int done_cyc);
    int n = 0;
    int cyc = 0;
    bit held = 1'b0;
    logic [31:0] hd = '0;
    logic [5:0]  hi = '0;
    for (int i = 0; i < 72; i++) cap[i] = 0;
    m_key = key; m_start = 1'b1; m_ready = 1'b1;
    @(negedge clk);
    m_start = 1'b0;
    cyc = 1;
    while (n < 44 && cyc < 2000) begin
      m_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (held) begin
        check("stall_data", m_data, hd);
        check("stall_idx", m_idx, hi);
      end
      held = 1'b0;
      check("valid_in_run", m_valid, 1);
      if (m_valid && m_ready) begin
        check("idx_seq", m_idx, n);
        cap[n] = m_data;
        n++;
      end else if (m_valid) begin
        held = 1'b1; hd = m_data; hi = m_idx;
      end
      @(negedge clk);
      cyc++;
    end
    check("key_count", n, 44);
    check("done_pulse", m_done, 1);
    check("valid_after_last", m_valid, 0);
    done_cyc = cyc;
    m_ready = 1'b1;
    @(negedge clk);
    check("done_one_cycle", m_done, 0);
  endtask

  typedef struct {
    logic [127:0] key;
    int           idx;
    logic [31:0]  exp;
  } vec_t;

  localparam logic [127:0] TV = 128'h1b1a1918_13121110_0b0a0908_03020100;

  initial begin
    vec_t tbl [7];
    longint unsigned cap0 [72];
    longint unsigned capt [72];
    longint unsigned caps [72];
    longint unsigned exp0 [72];
    longint unsigned expt [72];
    longint unsigned sel;
    int dc;
    int k;

    tbl[0] = '{128'd0, 0, 32'h00000000};
    tbl[1] = '{128'd0, 3, 32'h00000000};
    tbl[2] = '{128'd0, 4, 32'hFFFFFFFD};
    tbl[3] = '{128'd0, 5, 32'h9FFFFFFD};
    tbl[4] = '{TV,     0, 32'h03020100};
    tbl[5] = '{TV,     1, 32'h0b0a0908};
    tbl[6] = '{TV,     3, 32'h1b1a1918};

    rst_n = 1'b0; m_key = '0; m_start = 1'b0; m_abort = 1'b0; m_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", m_busy, 0);
    check("rst_valid", m_valid, 0);
    check("rst_data", m_data, 0);
    check("rst_idx", m_idx, 0);
    check("rst_done", m_done, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_main(128'd0, 1'b0, cap0, dc);
    check("done_cycle", dc, 45);
    run_main(TV, 1'b0, capt, dc);
    check("done_cycle_tv", dc, 45);

    for (int i = 0; i < 7; i++) begin
      sel = (tbl[i].key == 128'd0) ? cap0[tbl[i].idx] : capt[tbl[i].idx];
      check($sformatf("table%0d_k%0d", i, tbl[i].idx), sel, {32'd0, tbl[i].exp});
    end

    model_keys(32, 4, 3, 44, {128'd0, 128'd0}, exp0);
    model_keys(32, 4, 3, 44, {128'd0, TV}, expt);
    for (int i = 0; i < 44; i++) begin
      check($sformatf("zero_k%0d", i), cap0[i], exp0[i]);
      check($sformatf("tv_k%0d", i), capt[i], expt[i]);
    end

    run_main(TV, 1'b1, caps, dc);
    for (int i = 0; i < 44; i++) check($sformatf("stall_k%0d", i), caps[i], capt[i]);

    // abort together with start at rk_idx 10
    m_key = TV; m_start = 1'b1; m_ready = 1'b1;
    @(negedge clk);
    m_start = 1'b0;
    k = 0;
    while (m_idx != 6'd10 && k < 100) begin @(negedge clk); k++; end
    check("abort_reach_idx", m_idx, 10);
    m_abort = 1'b1; m_start = 1'b1;
    @(negedge clk);
    check("abort_busy", m_busy, 0);
    check("abort_valid", m_valid, 0);
    check("abort_done", m_done, 0);
    m_abort = 1'b0; m_start = 1'b0;
    @(negedge clk);
    check("abort_no_done", m_done, 0);
    check("abort_idle", m_valid, 0);
    m_start = 1'b1;
    @(negedge clk);
    m_start = 1'b0;
    check("restart_valid", m_valid, 1);
    check("restart_idx", m_idx, 0);
    check("restart_k0", m_data, expt[0]);

    // start held from the done cycle: ignored in DONE, accepted next in IDLE
    k = 0;
    while (!m_done && k < 200) begin @(negedge clk); k++; end
    check("reach_done", m_done, 1);
    m_start = 1'b1;
    @(negedge clk);
    check("start_in_done_ignored", m_valid, 0);
    check("start_in_done_busy", m_busy, 0);
    @(negedge clk);
    m_start = 1'b0;
    check("start_after_done_valid", m_valid, 1);
    check("start_after_done_idx", m_idx, 0);
    check("start_after_done_k0", m_data, expt[0]);
    m_abort = 1'b1;
    @(negedge clk);
    m_abort = 1'b0;

    sweep_go = 1'b1;
    k = 0;
    while (sweep_fin < 10 && k < 20000) begin @(negedge clk); k++; end
    check("sweep_finished", sweep_fin, 10);

    // asynchronous reset in the middle of a run
    m_key = TV; m_start = 1'b1; m_ready = 1'b1;
    @(negedge clk);
    m_start = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_reset_busy", m_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", m_busy, 0);
    check("async_rst_valid", m_valid, 0);
    check("async_rst_data", m_data, 0);
    check("async_rst_idx", m_idx, 0);
    check("async_rst_done", m_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #1_000_000;
    nerr++;
    $display("FAIL global_timeout: simulation did not complete");
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $fatal(1, "timeout");
  end

  // One instance per standard configuration, random keys with random backpressure
  for (genvar g = 0; g < 10; g++) begin : g_cfg
    localparam int CN  = CFG_N[g];
    localparam int CM  = CFG_M[g];
    localparam int CT  = CFG_T[g];
    localparam int CZ  = CFG_Z[g];
    localparam int CIW = $clog2(CT);

    logic [CN*CM-1:0] key;
    logic             start, abort, busy, valid, ready, done;
    logic [CN-1:0]    data;
    logic [CIW-1:0]   idx;

    simon_key_schedule #(.N(CN), .M(CM)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .key_in   (key),
      .start    (start),
      .abort    (abort),
      .busy     (busy),
      .rk_valid (valid),
      .rk_ready (ready),
      .rk_data  (data),
      .rk_idx   (idx),
      .done     (done)
    );

    initial begin
      longint unsigned expk [72];
      logic [255:0]    kb;
      longint unsigned wv;
      int n;
      int cyc;
      start = 1'b0; abort = 1'b0; ready = 1'b0; key = '0;
      wait (sweep_go);
      for (int tr = 0; tr < 3; tr++) begin
        kb = '0;
        for (int j = 0; j < CM; j++) begin
          if (tr == 0) wv = 64'hFFFF_FFFF_FFFF_FFFF;
          else wv = {$urandom, $urandom};
          kb[CN*j +: CN] = wv[CN-1:0];
        end
        key = kb[CN*CM-1:0];
        model_keys(CN, CM, CZ, CT, kb, expk);
        @(negedge clk);
        start = 1'b1; ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0; cyc = 0;
        while (n < CT && cyc < 2000) begin
          ready = ($urandom_range(0, 3) != 0);
          if (valid && ready) begin
            check($sformatf("cfg%0d_t%0d_idx", g, tr), idx, n);
            check($sformatf("cfg%0d_t%0d_k%0d", g, tr, n), data, expk[n]);
            n++;
          end
          @(negedge clk);
          cyc++;
        end
        check($sformatf("cfg%0d_t%0d_count", g, tr), n, CT);
        check($sformatf("cfg%0d_t%0d_done", g, tr), done, 1);
        @(negedge clk);
      end
      mark_sweep_done();
    end
  end

endmodule

// File: doc/simon_key_schedule.md
# simon_key_schedule

Parametrised, sequential Simon key-schedule generator. It loads a master key of M words of N bits each. It then streams the full round-key sequence k_0 … k_{T-1} over a valid/ready interface, one key per cycle at full throughput. A sliding window of M words is kept, so every round index i ≥ M is computed correctly, not just the first expanded word. It sits between the key register and the Simon round datapath, and covers all ten standard Simon block/key configurations.

## Interface
Parameters:
- N, 32, word width in bits; legal values 16, 24, 32, 48, 64.
- M, 4, number of key words; legal values 2, 3, 4.
- T, derived (not overridable), round count, taken from the package lookup on (N, M).
- ZI, derived, z-sequence index 0..4, taken from the package lookup on (N, M).
- IW, derived, equal to $clog2(T).

Ports:
- clk, input, 1, single clock; everything is rising-edge.
- rst_n, input, 1, asynchronous active-low reset.
- key_in, input, N*M, master key; word j is key_in[N*j +: N].
- start, input, 1, loads key_in and begins the sequence; accepted only in IDLE.
- abort, input, 1, synchronous return to IDLE.
- busy, output, 1, high in RUN.
- rk_valid, output, 1, round key available.
- rk_ready, input, 1, consumer accepts the round key.
- rk_data, output, N, current round key k_idx.
- rk_idx, output, IW, index of rk_data.
- done, output, 1, one-cycle pulse after k_{T-1} transfers.

## Operation
- Window registers w[0..M-1]. rk_data always equals w[0].
- Round counter cnt (IW bits). z pointer zp (6 bits).
- States:
  - IDLE: on start, load w[j] = key_in word j, cnt = 0, zp = 0, then go to RUN.
  - RUN: rk_valid = 1. On each transfer (rk_valid && rk_ready):
    - shift w[j] = w[j+1];
    - set w[M-1] = f(w);
    - cnt++ and zp++;
    - if cnt == T-1 at the transfer, go to DONE.
  - DONE: done = 1 for one cycle, then go to IDLE.
- Expansion function f, producing k_{cnt+M}:
  - t = ror(w[M-1], 3);
  - if M == 4, t ^= w[1];
  - t ^= ror(t, 1);
  - f = ~w[0] ^ t ^ {N-2 zeros, 2'b11} ^ z_bit, where z_bit enters the LSB.
- z_bit = Z[ZI][zp]. Bit 0 is the leftmost digit of the 62-bit constant as written.
- zp wraps from 61 to 0. This is required for 128/256, where cnt+M-M reaches 67.
- All arithmetic is modulo 2^N. Rotations are right rotations within N bits.
- When rk_valid is high and rk_ready is low, rk_data and rk_idx hold stable.
- start in RUN or DONE is ignored.
- abort in any state goes to IDLE next cycle with no done pulse. Window contents are don't-care after abort.
- abort and start asserted together: abort wins.
- An illegal (N, M) combination is an elaboration-time error.

## Timing
- Reset values: busy = 0, rk_valid = 0, rk_data = 0, rk_idx = 0, done = 0; state IDLE; window cleared.
- start sampled at edge c gives rk_valid = 1 with k_0 after edge c, i.e. one cycle of latency.
- With rk_ready held high, T keys appear on T consecutive cycles.
- done pulses in the cycle after the final transfer. rk_valid is low in that cycle.
- Earliest re-start is sampled while done = 1 is ignored. start is accepted the following cycle, in IDLE.
- f is a single combinational stage: a 2-rotate/XOR path of N bits. No pipelining.

## Structure
- Package simon_pkg holds:
  - the five z constants, each 62 bits;
  - the (N, M) → T lookup function;
  - the (N, M) → ZI lookup function;
  - the legal-configuration check;
  - the state enum {IDLE, RUN, DONE}.
- One sub-module, simon_ks_round: a purely combinational f(w, z_bit), parametrised by N and M.
- Counter, window and FSM live in the top module.

## Test plan
- N=32, M=4, key_in = 0, rk_ready = 1:
  - k_0 through k_3 = 0x00000000;
  - k_4 = 0xFFFFFFFD;
  - k_5 = 0x9FFFFFFD;
  - 44 keys on 44 consecutive cycles, rk_idx 0 to 43;
  - done pulses at cycle 45.
- N=32, M=4, key_in = 0x1b1a1918_13121110_0b0a0908_03020100:
  - k_0 = 0x03020100, k_3 = 0x1b1a1918;
  - all 44 keys match the golden model.
- Backpressure: toggle rk_ready pseudo-randomly.
  - rk_data and rk_idx stay stable while stalled.
  - The sequence is identical to the no-stall run.
- N=64, M=4, all-ones key:
  - 72 keys match the model;
  - confirms zp wraps at 61 (indices ≥ 66).
- abort at rk_idx = 10, asserted together with start:
  - next cycle busy = 0 and rk_valid = 0, with no done pulse;
  - a later start restarts at k_0.
- Sweep all 10 (N, M) configurations with random keys against the model.
- Assert rst_n low mid-RUN: all outputs return to reset values immediately, asynchronously.
